car_sensor_driver: RTL and testbench



---
 rtl/car_sensor_driver.sv | 133 +++++++++++++
 tb/tb_car_sensor_driver.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/car_sensor_driver.sv
// Gate-sensor stimulus generator: drives outer/inner sensor waveforms for
// car/pedestrian enter/exit crossings, D cycles per phase, R crossings per command.
module car_sensor_driver #(
  parameter int PHASE_W = 8,
  parameter int REP_W   = 5
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               start,
  input  logic [1:0]         cmd,
  input  logic [PHASE_W-1:0] dwell,
  input  logic [REP_W-1:0]   reps,
  input  logic               abort,
  output logic               outer,
  output logic               inner,
  output logic               busy,
  output logic               done
);

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_PH1  = 3'd1;
  localparam logic [2:0] ST_PH2  = 3'd2;
  localparam logic [2:0] ST_PH3  = 3'd3;
  localparam logic [2:0] ST_PH4  = 3'd4;

  localparam logic [PHASE_W-1:0] ONE_D = {{(PHASE_W-1){1'b0}}, 1'b1};
  localparam logic [REP_W-1:0]   ONE_R = {{(REP_W-1){1'b0}}, 1'b1};

  logic [2:0]         state_q, state_d;
  logic [1:0]         cmd_q, cmd_d;
  logic [PHASE_W-1:0] dwell_q, dwell_d;
  logic [PHASE_W-1:0] cnt_q, cnt_d;
  logic [REP_W-1:0]   reps_q, reps_d;
  logic               outer_q, outer_d;
  logic               inner_q, inner_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               phase_end;
  logic [1:0]         pat;

  // cmd[0] selects exit (inner first); cmd[1] selects pedestrian, whose PH2 is
  // a gap rather than both-blocked, so (1,1) can never occur for pedestrians.
  function automatic logic [1:0] phase_pat(input logic [1:0] c, input logic [2:0] st);
    logic [1:0] p;
    p = 2'b00;
    case (st)
      ST_PH1:  p = c[0] ? 2'b01 : 2'b10;
      ST_PH2:  p = c[1] ? 2'b00 : 2'b11;
      ST_PH3:  p = c[0] ? 2'b10 : 2'b01;
      default: p = 2'b00;
    endcase
    return p;
  endfunction

  assign phase_end = (cnt_q == dwell_q - ONE_D);

  always_comb begin
    state_d = state_q;
    cmd_d   = cmd_q;
    dwell_d = dwell_q;
    cnt_d   = cnt_q;
    reps_d  = reps_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    pat     = 2'b00;

    if (state_q == ST_IDLE) begin
      if (start && !abort) begin
        state_d = ST_PH1;
        cmd_d   = cmd;
        dwell_d = (dwell == '0) ? ONE_D : dwell;
        reps_d  = (reps == '0) ? ONE_R : reps;
        cnt_d   = '0;
        busy_d  = 1'b1;
      end
    end else if (abort) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
      reps_d  = '0;
      busy_d  = 1'b0;
    end else if (!phase_end) begin
      cnt_d = cnt_q + ONE_D;
    end else begin
      cnt_d = '0;
      if (state_q != ST_PH4) begin
        state_d = state_q + 3'd1;
      end else if (reps_q > ONE_R) begin
        state_d = ST_PH1;
        reps_d  = reps_q - ONE_R;
      end else begin
        state_d = ST_IDLE;
        reps_d  = '0;
        busy_d  = 1'b0;
        done_d  = 1'b1;
      end
    end

    // Outputs are registered from the next state so they line up with it.
    if (state_d != ST_IDLE) pat = phase_pat(cmd_d, state_d);
    outer_d = pat[1];
    inner_d = pat[0];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      cmd_q   <= '0;
      dwell_q <= '0;
      cnt_q   <= '0;
      reps_q  <= '0;
      outer_q <= 1'b0;
      inner_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cmd_q   <= cmd_d;
      dwell_q <= dwell_d;
      cnt_q   <= cnt_d;
      reps_q  <= reps_d;
      outer_q <= outer_d;
      inner_q <= inner_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign outer = outer_q;
  assign inner = inner_q;
  assign busy  = busy_q;
  assign done  = done_q;

endmodule

// File: tb/tb_car_sensor_driver.sv
// Directed bench for car_sensor_driver: phase waveforms, clamps, start/abort
// handshakes and async reset, checked cycle by cycle against hand tables.
module tb_car_sensor_driver;

  logic       clk;
  logic       reset_n;
  logic       start;
  logic [1:0] cmd;
  logic [7:0] dwell;
  logic [4:0] reps;
  logic       abort;
  logic       outer, inner, busy, done;

  int tests = 0;
  int fails = 0;

  car_sensor_driver #(.PHASE_W(8), .REP_W(5)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .cmd(cmd), .dwell(dwell),
    .reps(reps), .abort(abort), .outer(outer), .inner(inner), .busy(busy), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // Expected {outer,inner} per command and phase index 0..3.
  function automatic logic [1:0] exp_pat(input logic [1:0] c, input int ph);
    logic [1:0] p;
    p = 2'b00;
    case ({c, 2'(ph)})
      4'b00_00: p = 2'b10; 4'b00_01: p = 2'b11; 4'b00_10: p = 2'b01; 4'b00_11: p = 2'b00;
      4'b01_00: p = 2'b01; 4'b01_01: p = 2'b11; 4'b01_10: p = 2'b10; 4'b01_11: p = 2'b00;
      4'b10_00: p = 2'b10; 4'b10_01: p = 2'b00; 4'b10_10: p = 2'b01; 4'b10_11: p = 2'b00;
      4'b11_00: p = 2'b01; 4'b11_01: p = 2'b00; 4'b11_10: p = 2'b10; 4'b11_11: p = 2'b00;
      default:  p = 2'bxx;
    endcase
    return p;
  endfunction

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  // Called at a negedge; the following posedge is "cycle 0" of the command.
  task automatic launch(input logic [1:0] c, input logic [7:0] d, input logic [4:0] r);
    start = 1'b1;
    cmd   = c;
    dwell = d;
    reps  = r;
  endtask

  // Checks every busy cycle and the done cycle; scrambles cmd/dwell/reps
  // mid-sequence, and optionally pulses start while busy (index pulse_at).
  task automatic track(input logic [1:0] c, input int d, input int r, input int pulse_at);
    for (int i = 0; i < 4 * d * r; i++) begin
      @(negedge clk);
      start = (i == pulse_at);
      cmd   = 2'($urandom);
      dwell = 8'($urandom);
      reps  = 5'($urandom);
      chk($sformatf("cmd%0d_cyc%0d", c, i + 1), {outer, inner, busy, done},
          {exp_pat(c, (i / d) % 4), 2'b10});
      if (c[1]) chk($sformatf("ped_no_11_cyc%0d", i + 1), {3'b000, outer & inner}, 4'b0000);
    end
    @(negedge clk);
    start = 1'b0;
    chk($sformatf("cmd%0d_done", c), {outer, inner, busy, done}, 4'b0001);
  endtask

  task automatic idle_chk(input string tag);
    @(negedge clk);
    chk(tag, {outer, inner, busy, done}, 4'b0000);
  endtask

  initial begin
    reset_n = 1'b0;
    start   = 1'b0;
    abort   = 1'b0;
    cmd     = 2'b00;
    dwell   = 8'd0;
    reps    = 5'd0;
    #12;
    chk("reset_state", {outer, inner, busy, done}, 4'b0000);
    @(negedge clk);
    reset_n = 1'b1;
    idle_chk("idle_after_reset");

    // 1: car enter, D=2, R=1
    launch(2'b00, 8'd2, 5'd1);
    track(2'b00, 2, 1, -1);
    idle_chk("t1_done_one_cycle");

    // 2: car exit, D=1, R=16
    launch(2'b01, 8'd1, 5'd16);
    track(2'b01, 1, 16, -1);
    idle_chk("t2_done_one_cycle");

    // 3: pedestrian enter with zero dwell/reps clamps to D=1, R=1
    launch(2'b10, 8'd0, 5'd0);
    track(2'b10, 1, 1, -1);
    idle_chk("t3_done_one_cycle");

    // 4a: start pulse while busy is ignored
    launch(2'b00, 8'd1, 5'd2);
    track(2'b00, 1, 2, 3);
    idle_chk("t4a_not_queued");

    // 4b: start in the done cycle begins a new sequence next cycle
    launch(2'b01, 8'd1, 5'd1);
    track(2'b01, 1, 1, -1);
    launch(2'b11, 8'd1, 5'd1);
    track(2'b11, 1, 1, -1);
    idle_chk("t4b_idle");

    // 5: abort mid-PH2 of car enter, D=2
    launch(2'b00, 8'd2, 5'd1);
    @(negedge clk); start = 1'b0;
    chk("t5_cyc1", {outer, inner, busy, done}, 4'b1010);
    @(negedge clk);
    chk("t5_cyc2", {outer, inner, busy, done}, 4'b1010);
    @(negedge clk);
    chk("t5_cyc3_ph2", {outer, inner, busy, done}, 4'b1110);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("t5_abort_out", {outer, inner, busy, done}, 4'b0000);
    idle_chk("t5_abort_no_done");
    start = 1'b1;
    abort = 1'b1;
    idle_chk("t5_abort_beats_start");
    start = 1'b0;
    abort = 1'b0;
    idle_chk("t5_start_dropped");
    launch(2'b00, 8'd1, 5'd1);
    track(2'b00, 1, 1, -1);
    idle_chk("t5_post_run_idle");

    // 6: async reset mid-PH3 of car enter, D=2 (PH3 = cycles 5-6)
    launch(2'b00, 8'd2, 5'd1);
    @(negedge clk); start = 1'b0;
    repeat (4) @(negedge clk);
    chk("t6_cyc5_ph3", {outer, inner, busy, done}, 4'b0110);
    #2 reset_n = 1'b0;
    #1 chk("t6_async_reset", {outer, inner, busy, done}, 4'b0000);
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    idle_chk("t6_after_release");
    idle_chk("t6_no_spurious_done");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
